// File: rtl/alu_sequencer.sv
// Stack-execution controller: pops two operands, drives the ALU (or the internal
// restoring divider for DIV) and pushes the single result back.
module alu_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [3:0]         cmd_func,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   stk_top,
    input  logic [DEPTH_W-1:0] stk_depth,
    output logic               pop,
    output logic               push,
    output logic [WIDTH-1:0]   push_data,
    output logic [3:0]         alu_func,
    output logic [WIDTH-1:0]   alu_i0,
    output logic [WIDTH-1:0]   alu_i1,
    input  logic [WIDTH-1:0]   alu_o0,
    output logic               done,
    output logic               err_underflow,
    output logic               err_illegal,
    output logic               err_div0
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [3:0] FUNC_R1  = 4'd0;
    localparam logic [3:0] FUNC_R2  = 4'd1;
    localparam logic [3:0] FUNC_DIV = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_B,
        S_POP_A,
        S_EXEC,
        S_DIV,
        S_PUSH
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         func_q, func_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div0_q, div0_d, errIll_q, errIll_d, errUnd_q, errUnd_d;
    logic [WIDTH:0]     remShift;
    logic [WIDTH-1:0]   quoNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            div0_q   <= 1'b0;
            errIll_q <= 1'b0;
            errUnd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            div0_q   <= div0_d;
            errIll_q <= errIll_d;
            errUnd_q <= errUnd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        div0_d   = div0_q;
        errIll_d = 1'b0;
        errUnd_d = 1'b0;
        remShift = {rem_q, quo_q[WIDTH-1]};
        quoNext  = {quo_q[WIDTH-2:0], 1'b0};

        case (state_q)
            S_IDLE: begin
                div0_d = 1'b0;
                if (cmd_valid) begin
                    func_d = cmd_func;
                    if (cmd_func > FUNC_DIV) begin
                        errIll_d = 1'b1;
                    end else if (stk_depth < DEPTH_W'(2)) begin
                        errUnd_d = 1'b1;
                    end else begin
                        state_d = S_POP_B;
                    end
                end
            end
            S_POP_B: begin
                b_d     = stk_top;
                state_d = S_POP_A;
            end
            S_POP_A: begin
                a_d = stk_top;
                if (func_q == FUNC_DIV) begin
                    rem_d   = '0;
                    quo_d   = stk_top;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (func_q)
                    FUNC_R1: result_d = a_q;
                    FUNC_R2: result_d = b_q;
                    default: result_d = alu_o0;
                endcase
                state_d = S_PUSH;
            end
            S_DIV: begin
                if (b_q == '0) begin
                    result_d = '1;
                    div0_d   = 1'b1;
                    state_d  = S_PUSH;
                end else begin
                    // Restoring step: the dividend shifts out of quo_q while quotient bits shift in.
                    if (remShift >= {1'b0, b_q}) begin
                        rem_d      = WIDTH'(remShift - {1'b0, b_q});
                        quoNext[0] = 1'b1;
                    end else begin
                        rem_d = remShift[WIDTH-1:0];
                    end
                    quo_d = quoNext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = quoNext;
                        state_d  = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are masked by rst so nothing reaches the stack during the reset cycle.
    assign cmd_ready     = (state_q == S_IDLE);
    assign pop           = !rst && ((state_q == S_POP_B) || (state_q == S_POP_A));
    assign push          = !rst && (state_q == S_PUSH);
    assign push_data     = result_q;
    assign alu_func      = (state_q == S_EXEC) ? func_q : 4'd0;
    assign alu_i0        = a_q;
    assign alu_i1        = b_q;
    assign err_illegal   = !rst && errIll_q;
    assign err_underflow = !rst && errUnd_q;
    assign err_div0      = !rst && (state_q == S_PUSH) && div0_q;
    assign done          = push || err_illegal || err_underflow;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural stack and ALU around it.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_func = 4'd0;
    logic        cmd_ready;
    logic [15:0] stk_top;
    logic [7:0]  stk_depth;
    logic        pop, push, done, err_underflow, err_illegal, err_div0;
    logic [15:0] push_data, alu_i0, alu_i1;
    logic [15:0] alu_o0;
    logic [3:0]  alu_func;

    int checks = 0;
    int failures = 0;
    int edgeCount = 0;
    int popCount = 0;

    logic [15:0] mem [0:31];
    int          sp = 0;
    logic        clr = 1'b0;
    logic        loadEn = 1'b0;
    logic [15:0] loadVal = 16'd0;

    typedef struct {
        logic [15:0] data;
        logic        eU;
        logic        eI;
        logic        eD;
        logic [3:0]  func;
        logic [15:0] a;
        logic [15:0] b;
        int          pops;
        int          doneAt;
    } exp_t;

    exp_t sb[$];

    alu_sequencer #(.WIDTH(16), .DEPTH_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_func(cmd_func),
        .cmd_ready(cmd_ready), .stk_top(stk_top), .stk_depth(stk_depth),
        .pop(pop), .push(push), .push_data(push_data), .alu_func(alu_func),
        .alu_i0(alu_i0), .alu_i1(alu_i1), .alu_o0(alu_o0), .done(done),
        .err_underflow(err_underflow), .err_illegal(err_illegal), .err_div0(err_div0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    always_comb begin
        alu_o0 = 16'd0;
        case (alu_func)
            4'd0: alu_o0 = alu_i0;
            4'd1: alu_o0 = alu_i1;
            4'd2: alu_o0 = alu_i0 + alu_i1;
            4'd3: alu_o0 = alu_i0 - alu_i1;
            4'd4: alu_o0 = 16'(alu_i0 * alu_i1);
            default: alu_o0 = 16'd0;
        endcase
    end

    assign stk_depth = 8'(sp);
    assign stk_top   = (sp > 0) ? mem[sp-1] : 16'd0;

    always @(posedge clk) begin
        if (clr) sp <= 0;
        else if (loadEn) begin
            mem[sp] <= loadVal;
            sp <= sp + 1;
        end else if (pop && sp > 0) sp <= sp - 1;
        else if (push) begin
            mem[sp] <= push_data;
            sp <= sp + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compares every completion against the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            popCount = 0;
        end else begin
            if (pop) popCount++;
            if (alu_func != 4'd0 && sb.size() > 0) begin
                checkOutput("alu_func", 32'(alu_func), 32'(sb[0].func));
                checkOutput("alu_i0", 32'(alu_i0), 32'(sb[0].a));
                checkOutput("alu_i1", 32'(alu_i1), 32'(sb[0].b));
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done_push", {30'd0, done, push}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("done_cycle", 32'(edgeCount), 32'(e.doneAt));
                    checkOutput("push", 32'(push), (e.pops == 2) ? 32'd1 : 32'd0);
                    if (push) checkOutput("push_data", 32'(push_data), 32'(e.data));
                    checkOutput("err_flags", {29'd0, err_underflow, err_illegal, err_div0},
                                {29'd0, e.eU, e.eI, e.eD});
                    checkOutput("pop_count", 32'(popCount), 32'(e.pops));
                end
                popCount = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] f, input logic [15:0] d,
                                 input logic eU, input logic eI, input logic eD,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input int pops, input int lat, input bit track,
                                 output int acc);
        exp_t e;
        int n;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) checkOutput("ready_timeout", 32'(cmd_ready), 32'd1);
        e.data = d; e.eU = eU; e.eI = eI; e.eD = eD; e.func = f;
        e.a = a; e.b = b; e.pops = pops; e.doneAt = edgeCount + lat;
        if (track) sb.push_back(e);
        acc = edgeCount + 1;
        cmd_valid = 1'b1;
        cmd_func  = f;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_func  = 4'hF;
    endtask

    task automatic clearStack();
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic pushVal(input logic [15:0] v);
        loadVal = v;
        loadEn  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    task automatic load2(input logic [15:0] a, input logic [15:0] b);
        clearStack();
        pushVal(a);
        pushVal(b);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((sb.size() > 0 || !cmd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc1, acc2;
        $display("[TB] start");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_strobes", {26'd0, pop, push, done, err_underflow, err_illegal, err_div0}, 32'd0);
        checkOutput("rst_push_data", 32'(push_data), 32'd0);
        checkOutput("rst_alu", {alu_func, 12'd0, alu_i0 | alu_i1}, 32'd0);
        rst = 1'b0;

        // ADD 7+3, then the stack must hold just the result
        load2(16'd7, 16'd3);
        applyStimulus(4'd2, 16'd10, 0, 0, 0, 16'd7, 16'd3, 2, 4, 1, acc1);
        waitIdle();
        checkOutput("add_depth", 32'(sp), 32'd1);
        checkOutput("add_top", 32'(stk_top), 32'd10);

        load2(16'd2, 16'd5);
        applyStimulus(4'd3, 16'hFFFD, 0, 0, 0, 16'd2, 16'd5, 2, 4, 1, acc1);
        waitIdle();
        load2(16'd300, 16'd300);
        applyStimulus(4'd4, 16'h5F90, 0, 0, 0, 16'd300, 16'd300, 2, 4, 1, acc1);
        waitIdle();
        load2(16'd100, 16'd7);
        applyStimulus(4'd5, 16'd14, 0, 0, 0, 16'd100, 16'd7, 2, 19, 1, acc1);
        waitIdle();
        load2(16'd5, 16'd0);
        applyStimulus(4'd5, 16'hFFFF, 0, 0, 1, 16'd5, 16'd0, 2, 4, 1, acc1);
        waitIdle();
        load2(16'hFFFF, 16'd1);
        applyStimulus(4'd5, 16'hFFFF, 0, 0, 0, 16'hFFFF, 16'd1, 2, 19, 1, acc1);
        waitIdle();
        load2(16'h1234, 16'hABCD);
        applyStimulus(4'd0, 16'h1234, 0, 0, 0, 16'h1234, 16'hABCD, 2, 4, 1, acc1);
        waitIdle();
        load2(16'h1234, 16'hABCD);
        applyStimulus(4'd1, 16'hABCD, 0, 0, 0, 16'h1234, 16'hABCD, 2, 4, 1, acc1);
        waitIdle();

        // Underflow then illegal, the second accepted one cycle after the first
        clearStack();
        pushVal(16'd42);
        applyStimulus(4'd2, 16'd0, 1, 0, 0, 16'd0, 16'd0, 0, 1, 1, acc1);
        applyStimulus(4'd9, 16'd0, 0, 1, 0, 16'd0, 16'd0, 0, 1, 1, acc2);
        checkOutput("reject_accept_gap", 32'(acc2 - acc1), 32'd1);
        waitIdle();
        checkOutput("reject_depth", 32'(sp), 32'd1);

        // Back-to-back ADDs: 3+4=7, then 2+7=9
        clearStack();
        pushVal(16'd1);
        pushVal(16'd2);
        pushVal(16'd3);
        pushVal(16'd4);
        applyStimulus(4'd2, 16'd7, 0, 0, 0, 16'd3, 16'd4, 2, 4, 1, acc1);
        applyStimulus(4'd2, 16'd9, 0, 0, 0, 16'd2, 16'd7, 2, 4, 1, acc2);
        checkOutput("b2b_accept_gap", 32'(acc2 - acc1), 32'd5);
        waitIdle();
        checkOutput("b2b_depth", 32'(sp), 32'd2);
        checkOutput("b2b_top", 32'(stk_top), 32'd9);

        // Reset in cycle 8 of a DIV: the op is abandoned and never pushes
        load2(16'd100, 16'd7);
        applyStimulus(4'd5, 16'd0, 0, 0, 0, 16'd0, 16'd0, 2, 19, 0, acc1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_div_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_div_push", {30'd0, push, pop}, 32'd0);
        repeat (25) @(negedge clk);
        checkOutput("rst_div_depth", 32'(sp), 32'd0);
        checkOutput("rst_div_push_data", 32'(push_data), 32'd0);

        load2(16'd7, 16'd3);
        applyStimulus(4'd2, 16'd10, 0, 0, 0, 16'd7, 16'd3, 2, 4, 1, acc1);
        waitIdle();
        checkOutput("post_rst_top", 32'(stk_top), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Stack-execution controller that sequences the 16-bit combinational ALU for arithmetic instructions. It accepts an operation code from the instruction decoder, pops two operands from the data stack and drives the ALU. It writes the result back with a single push. The ALU returns 0 for DIV, so this block computes DIV itself with a multi-cycle restoring divider.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must match the ALU and stack data width.
- DEPTH_W, 8, width of the stack depth input.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  decoder presents an operation.
- cmd_func  in  4  operation: 0 R1, 1 R2, 2 ADD, 3 SUB, 4 MUL, 5 DIV; 6–15 illegal.
- cmd_ready  out  1  high only in IDLE; command accepted on clk edge with cmd_valid && cmd_ready.
- stk_top  in  WIDTH  current top-of-stack value; reflects a pop on the following cycle.
- stk_depth  in  DEPTH_W  number of valid stack entries.
- pop  out  1  one-cycle pop strobe to the stack.
- push  out  1  one-cycle push strobe to the stack.
- push_data  out  WIDTH  value written when push=1.
- alu_func  out  4  ALU function select.
- alu_i0, alu_i1  out  WIDTH  ALU operands.
- alu_o0  in  WIDTH  ALU result (combinational).
- done  out  1  one-cycle pulse coincident with push, or with error completion.
- err_underflow, err_illegal, err_div0  out  1  one-cycle error pulses.

## Operation
- Operand order: B = first pop (old top), A = second pop. Result = A op B; ALU driven with alu_i0=A, alu_i1=B.
- R1 → result A. R2 → result B. ADD/SUB/MUL → alu_o0 (low WIDTH bits; wrap-around, unsigned). DIV → unsigned floor(A/B), computed internally; ALU not used.
- Net stack effect of every legal op: −2 pops, +1 push. The block never pushes before both pops, so no overflow is possible.
- States: IDLE → POP_B → POP_A → EXEC → PUSH → IDLE; for DIV: POP_A → DIV (WIDTH iterations) → PUSH.
- IDLE: on accept, latch func. If func>5: pulse err_illegal+done next cycle, stay IDLE, no pops. Else if stk_depth<2: pulse err_underflow+done next cycle, stay IDLE, no pops. Else go to POP_B.
- POP_B: pop=1, B←stk_top. POP_A: pop=1, A←stk_top.
- EXEC: alu_func=latched func, result←alu_o0. alu_func=0 in every other state; alu_i0/alu_i1 always show the A/B registers.
- DIV: if B==0, result←{WIDTH{1'b1}}, pulse err_div0 with done in PUSH, skip iterations. Else run a restoring shift-subtract, one quotient bit per cycle, MSB first, WIDTH cycles; remainder discarded.
- PUSH: push=1, push_data=result, done=1, return to IDLE.
- rst (any state, including mid-DIV): next edge state=IDLE; A, B, result and the divider registers are cleared; no pop/push is issued in the reset cycle or after it. A partially popped operation is abandoned; stack recovery is the decoder's responsibility.

## Timing
- Reset values: pop, push, done, all err_* = 0; push_data, alu_i0, alu_i1, alu_func = 0; cmd_ready = 1 once state=IDLE (first edge with rst high).
- All outputs except cmd_ready are registered or decoded from state/registers; there are no combinational paths from cmd_* to outputs.
- Cycle numbering is relative to the accept edge (cycle 0).
- Non-DIV: pop in cycles 1 and 2, EXEC in cycle 3, push/done in cycle 4, cmd_ready high in cycle 5. Throughput is 1 op per 5 cycles.
- DIV, B≠0: iterations in cycles 3..WIDTH+2 (3..18), push/done in cycle 19, ready in cycle 20.
- DIV, B=0: push/done/err_div0 in cycle 4.
- Error rejects (illegal, underflow): err_*+done in cycle 1, cmd_ready stays high, next command accepted in cycle 1.
- cmd_func is sampled only at accept; later changes are ignored.

## Test plan
- Stack [.., 7, 3] (3 on top), ADD → pops at cycles 1,2, push_data=10 at cycle 4, done=1; alu_i0=7, alu_i1=3 in EXEC.
- SUB 2−5 (A=2, B=5) → push_data=16'hFFFD. MUL 300×300 → 16'h5F90 (90000 mod 65536).
- DIV 100/7 → push_data=14 at cycle 19. DIV 5/0 → push_data=16'hFFFF, err_div0+done at cycle 4. DIV 16'hFFFF/1 → 16'hFFFF.
- stk_depth=1, ADD → err_underflow+done at cycle 1, no pop/push. cmd_func=9 → err_illegal, no stack activity. Back-to-back cmd_valid → second accept exactly at cycle 5.
- rst asserted at cycle 8 of a DIV → push never asserted, IDLE and cmd_ready=1 after the reset edge. A following ADD completes normally.
- R1 and R2 on A=0x1234, B=0xABCD → push 0x1234 and 0xABCD respectively.
